seq_mul: RTL and testbench

- Iterative radix-2 shift-add multiplier for the RV64M execute stage; the multiply counterpart to the sequential divider.
- Covers MUL, MULH, MULHSU and MULHU with one shared datapath: one product bit per cycle, fixed latency, start/done handshake.
- Sits beside the divider behind the M-extension issue logic.

---
 rtl/seq_mul_pkg.sv | 35 +++
 rtl/seq_mul_if.sv | 40 ++++
 rtl/seq_mul.sv | 108 ++++++++++
 tb/tb_seq_mul.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mul_pkg.sv
// -----------------------------------------------------------------------------
// mul_pkg
// Shared definitions for the sequential RV64M multiplier.
//   - op encodings (the issue logic uses the same encoding)
//   - FSM state type
//   - cond_neg(): conditional two's-complement negate. It is used both for
//     operand magnitude prep and for the final product sign fix.
// No ports (package).
// -----------------------------------------------------------------------------
package mul_pkg;

    localparam logic [1:0] MUL_LO  = 2'b00;  // MUL    : low half
    localparam logic [1:0] MUL_HSS = 2'b01;  // MULH   : high half, signed x signed
    localparam logic [1:0] MUL_HSU = 2'b10;  // MULHSU : high half, signed x unsigned
    localparam logic [1:0] MUL_HUU = 2'b11;  // MULHU  : high half, unsigned x unsigned

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Working width of cond_neg. Callers zero-extend into it and truncate the
    // result back. The low N bits of a two's-complement negation depend only
    // on the low N bits of the input, so one wide function serves every
    // width up to NEG_W (covers 2*XLEN for XLEN <= 128).
    localparam int NEG_W = 256;

    function automatic logic [NEG_W-1:0] cond_neg(input logic [NEG_W-1:0] x,
                                                  input logic             en);
        return en ? (~x + NEG_W'(1)) : x;
    endfunction

endpackage

// File: rtl/seq_mul_if.sv
// -----------------------------------------------------------------------------
// seq_mul_if
// Request/result bundle between the M-extension issue logic and seq_mul.
//
// Handshake: the issuer raises start together with op/a/b. The request is
// taken at the first rising Clk edge where start=1 and the multiplier is idle
// (busy=0 and not in its done cycle); a start at any other time is dropped,
// never queued. Operands are latched on acceptance and may change freely
// afterwards. done is a one-cycle pulse marking y valid; y then holds until
// the next accepted request finishes.
//
// Signals:
//   start  master->slave  request
//   op     master->slave  2-bit op (see mul_pkg)
//   a, b   master->slave  rs1 / rs2 operands
//   busy   slave->master  operation in progress
//   done   slave->master  result-valid pulse
//   y      slave->master  result
// -----------------------------------------------------------------------------
interface seq_mul_if #(
    parameter int XLEN = 64
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] y;

    modport master (
        output start, op, a, b,
        input  busy, done, y
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, y
    );
endinterface

// File: rtl/seq_mul.sv
// -----------------------------------------------------------------------------
// seq_mul
// Iterative radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU.
// The operands are reduced to unsigned magnitudes with a latched result sign.
// One product bit is retired per cycle for XLEN cycles, then the sign is
// applied and the requested half is selected in one extra cycle. Latency
// is fixed, so there is no early exit for small operands.
//
// Ports:
//   Clk    in   rising-edge clock
//   Rst    in   synchronous, active-low reset
//   bus    slave modport of seq_mul_if (start/op/a/b in, busy/done/y out)
//   state  out  current FSM state, for observation
// -----------------------------------------------------------------------------
module seq_mul
    import mul_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic        Clk,
    input  logic        Rst,
    seq_mul_if.slave    bus,
    output state_t      state
);

    logic [1:0]        op_q;
    logic              neg;
    logic [XLEN-1:0]   ma;
    logic [2*XLEN-1:0] acc;
    logic [CNT_W-1:0]  cnt;

    logic              sa;
    logic              sb;
    logic [XLEN-1:0]   ma_in;
    logic [XLEN-1:0]   mb_in;
    logic [XLEN:0]     sum;
    logic [2*XLEN-1:0] p;

    always_comb begin
        // Only the signed operand positions of each op contribute a sign.
        sa    = bus.a[XLEN-1] & ((bus.op == MUL_HSS) | (bus.op == MUL_HSU));
        sb    = bus.b[XLEN-1] & (bus.op == MUL_HSS);
        // Negating the most negative value wraps back to 2^(XLEN-1), which
        // is the correct unsigned magnitude.
        ma_in = XLEN'(cond_neg(NEG_W'(bus.a), sa));
        mb_in = XLEN'(cond_neg(NEG_W'(bus.b), sb));
        // Partial-product add into the upper half, keeping the carry bit.
        sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, ma} : '0);
        p     = (2*XLEN)'(cond_neg(NEG_W'(acc), neg));
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state    <= IDLE;
            op_q     <= MUL_LO;
            neg      <= 1'b0;
            ma       <= '0;
            acc      <= '0;
            cnt      <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.y    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_q     <= bus.op;
                        neg      <= sa ^ sb;
                        ma       <= ma_in;
                        acc      <= {{XLEN{1'b0}}, mb_in};
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= CALC;
                    end
                end

                CALC: begin
                    // {carry, upper, lower} >> 1: the multiplier bits drain
                    // out of the bottom while product bits fill from the top.
                    acc <= {sum, acc[XLEN-1:1]};
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(XLEN - 1)) begin
                        state <= FIX;
                    end
                end

                FIX: begin
                    bus.y    <= (op_q == MUL_LO) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
                    bus.busy <= 1'b0;
                    bus.done <= 1'b1;
                    state    <= DONE;
                end

                DONE: begin
                    // start is deliberately not sampled here.
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mul.sv
// -----------------------------------------------------------------------------
// tb_seq_mul
// Self-checking bench for seq_mul (XLEN=64). The reference model takes the
// 128-bit product of sign- or zero-extended operands and selects a half.
// -----------------------------------------------------------------------------
module tb_seq_mul;
    import mul_pkg::*;

    localparam int XLEN = 64;
    localparam int LAT  = XLEN + 2;

    logic   Clk;
    logic   Rst;
    state_t dbg_state;
    int     n_checks;
    int     n_pass;

    seq_mul_if #(.XLEN(XLEN)) bus ();

    seq_mul #(.XLEN(XLEN)) dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .bus   (bus),
        .state (dbg_state)
    );

    // ---------------- clock ----------------
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ---------------- reference model ----------------
    function automatic logic [63:0] ref_mul(input logic [1:0] o, input logic [63:0] x,
                                            input logic [63:0] z);
        logic signed [127:0] ex;
        logic signed [127:0] ez;
        logic signed [127:0] prod;
        ex   = (o == 2'b01 || o == 2'b10) ? {{64{x[63]}}, x} : {64'b0, x};
        ez   = (o == 2'b01) ? {{64{z[63]}}, z} : {64'b0, z};
        prod = ex * ez;
        return (o == 2'b00) ? prod[63:0] : prod[127:64];
    endfunction

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 7))
            0:       return 64'h0;
            1:       return 64'h1;
            2:       return 64'hFFFF_FFFF_FFFF_FFFF;
            3:       return 64'h8000_0000_0000_0000;
            4:       return 64'h7FFF_FFFF_FFFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // ---------------- driver ----------------
    // Starts one op at a negedge and waits for done. lat counts rising edges
    // from the accepting edge (1) to the edge after which done is seen.
    task automatic do_op(input logic [1:0] o, input logic [63:0] x, input logic [63:0] z,
                         output logic [63:0] res, output int lat, output int busy_cycles);
        @(negedge Clk);
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = x;
        bus.b     = z;
        busy_cycles = 0;
        @(negedge Clk);
        bus.start = 1'b0;
        lat = 1;
        if (bus.busy) busy_cycles++;
        while (!bus.done && lat < 200) begin
            @(negedge Clk);
            lat++;
            if (bus.busy) busy_cycles++;
        end
        res = bus.y;
    endtask

    task automatic apply_reset();
        @(negedge Clk);
        Rst = 1'b0;
        repeat (3) @(negedge Clk);
        Rst = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.y !== 64'h0 || dbg_state !== IDLE)
            $display("FAIL reset busy=%b done=%b y=%h state=%0d, need 0/0/0/IDLE",
                     bus.busy, bus.done, bus.y, dbg_state);
        else n_pass++;
    endtask

    task automatic test_basic_mul();
        logic [63:0] r;
        int lat, bc;
        do_op(2'b00, 64'd6, 64'd7, r, lat, bc);
        n_checks++;
        if (r !== 64'd42) $display("FAIL basic_y got=%h need=%h", r, 64'd42);
        else n_pass++;
        n_checks++;
        if (lat !== LAT) $display("FAIL basic_latency got=%0d need=%0d", lat, LAT);
        else n_pass++;
        n_checks++;
        if (bc !== LAT - 1) $display("FAIL basic_busy_cycles got=%0d need=%0d", bc, LAT - 1);
        else n_pass++;
    endtask

    task automatic test_directed();
        logic [1:0]  t_op  [10];
        logic [63:0] t_a   [10];
        logic [63:0] t_b   [10];
        logic [63:0] t_exp [10];
        logic [63:0] r;
        int lat, bc;
        t_op[0] = 2'b11; t_a[0] = '1;                     t_b[0] = '1;     t_exp[0] = 64'hFFFF_FFFF_FFFF_FFFE;
        t_op[1] = 2'b00; t_a[1] = '1;                     t_b[1] = '1;     t_exp[1] = 64'h0000_0000_0000_0001;
        t_op[2] = 2'b01; t_a[2] = 64'h8000_0000_0000_0000; t_b[2] = 64'h8000_0000_0000_0000;
                         t_exp[2] = 64'h4000_0000_0000_0000;
        t_op[3] = 2'b01; t_a[3] = '1;                     t_b[3] = '1;     t_exp[3] = 64'h0;
        t_op[4] = 2'b01; t_a[4] = -64'sd3;                t_b[4] = 64'd5;  t_exp[4] = 64'hFFFF_FFFF_FFFF_FFFF;
        t_op[5] = 2'b00; t_a[5] = -64'sd3;                t_b[5] = 64'd5;  t_exp[5] = 64'hFFFF_FFFF_FFFF_FFF1;
        t_op[6] = 2'b10; t_a[6] = '1;                     t_b[6] = '1;     t_exp[6] = 64'hFFFF_FFFF_FFFF_FFFF;
        t_op[7] = 2'b11; t_a[7] = '1;                     t_b[7] = '1;     t_exp[7] = 64'hFFFF_FFFF_FFFF_FFFE;
        t_op[8] = 2'b01; t_a[8] = 64'h0;                  t_b[8] = '1;     t_exp[8] = 64'h0;
        t_op[9] = 2'b00; t_a[9] = 64'h1234_5678_9ABC_DEF0; t_b[9] = 64'h0; t_exp[9] = 64'h0;
        for (int i = 0; i < 10; i++) begin
            do_op(t_op[i], t_a[i], t_b[i], r, lat, bc);
            n_checks++;
            if (r !== t_exp[i] || lat !== LAT)
                $display("FAIL directed_%0d op=%0d got=%h lat=%0d need=%h lat=%0d",
                         i, t_op[i], r, lat, t_exp[i], LAT);
            else n_pass++;
        end
    endtask

    task automatic test_handshake();
        logic [63:0] exp_y;
        logic [63:0] held;
        int lat;
        int changed;
        exp_y = ref_mul(2'b10, 64'hFEDC_BA98_7654_3210, 64'h0000_0000_DEAD_BEEF);
        @(negedge Clk);
        bus.start = 1'b1;
        bus.op    = 2'b10;
        bus.a     = 64'hFEDC_BA98_7654_3210;
        bus.b     = 64'h0000_0000_DEAD_BEEF;
        @(negedge Clk);
        bus.start = 1'b0;
        lat = 1;
        // Scramble inputs and fire stray starts in CALC and in FIX.
        while (!bus.done && lat < 200) begin
            if (lat < 66) begin
                bus.a  = {$urandom, $urandom};
                bus.b  = {$urandom, $urandom};
                bus.op = 2'($urandom_range(0, 3));
            end
            bus.start = (lat == 10 || lat == 40 || lat == 65);
            @(negedge Clk);
            lat++;
        end
        bus.start = 1'b0;
        n_checks++;
        if (bus.y !== exp_y || lat !== LAT)
            $display("FAIL ignore_busy_start got=%h lat=%0d need=%h lat=%0d", bus.y, lat, exp_y, LAT);
        else n_pass++;

        // Start raised during the done cycle must be dropped.
        held      = bus.y;
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.a     = 64'd3;
        bus.b     = 64'd3;
        @(negedge Clk);
        bus.start = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b0 || dbg_state !== IDLE)
            $display("FAIL ignore_done_start busy=%b state=%0d need busy=0 state=IDLE",
                     bus.busy, dbg_state);
        else n_pass++;

        // y holds while idle.
        changed = 0;
        repeat (10) begin
            @(negedge Clk);
            if (bus.y !== held || bus.done !== 1'b0) changed++;
        end
        n_checks++;
        if (changed !== 0) $display("FAIL y_stable changes=%0d need=0 y=%h held=%h", changed, bus.y, held);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [63:0] r;
        int lat, bc;
        do_op(2'b01, 64'hFFFF_FFFF_FFFF_FFF0, 64'h0000_0000_0000_0100, r, lat, bc);
        n_checks++;
        if (r !== ref_mul(2'b01, 64'hFFFF_FFFF_FFFF_FFF0, 64'h100) || lat !== LAT)
            $display("FAIL b2b_first got=%h lat=%0d", r, lat);
        else n_pass++;
        // Issued on the cycle right after done.
        do_op(2'b00, 64'h0000_0001_0000_0003, 64'h0000_0002_0000_0005, r, lat, bc);
        n_checks++;
        if (r !== 64'h0000_000B_0000_000F || lat !== LAT)
            $display("FAIL b2b_second got=%h lat=%0d need=%h lat=%0d", r, lat, 64'h0000_000B_0000_000F, LAT);
        else n_pass++;
    endtask

    task automatic test_reset_mid_op();
        logic [63:0] r;
        int lat, bc;
        int seen_done;
        @(negedge Clk);
        bus.start = 1'b1;
        bus.op    = 2'b11;
        bus.a     = 64'hAAAA_5555_AAAA_5555;
        bus.b     = 64'h1234_0000_5678_9999;
        @(negedge Clk);
        bus.start = 1'b0;
        repeat (30) @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);
        Rst = 1'b1;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.y !== 64'h0 || dbg_state !== IDLE)
            $display("FAIL mid_reset busy=%b done=%b y=%h state=%0d need 0/0/0/IDLE",
                     bus.busy, bus.done, bus.y, dbg_state);
        else n_pass++;
        seen_done = 0;
        repeat (100) begin
            @(negedge Clk);
            if (bus.done) seen_done++;
        end
        n_checks++;
        if (seen_done !== 0) $display("FAIL mid_reset_no_done pulses=%0d need=0", seen_done);
        else n_pass++;
        do_op(2'b11, 64'hAAAA_5555_AAAA_5555, 64'h1234_0000_5678_9999, r, lat, bc);
        n_checks++;
        if (r !== ref_mul(2'b11, 64'hAAAA_5555_AAAA_5555, 64'h1234_0000_5678_9999) || lat !== LAT)
            $display("FAIL mid_reset_restart got=%h lat=%0d", r, lat);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [63:0] x, z, r, e;
        logic [1:0]  o;
        int lat, bc;
        for (int i = 0; i < 800; i++) begin
            o = 2'($urandom_range(0, 3));
            x = pick();
            z = pick();
            e = ref_mul(o, x, z);
            do_op(o, x, z, r, lat, bc);
            n_checks++;
            if (r !== e || lat !== LAT)
                $display("FAIL random_%0d op=%0d a=%h b=%h got=%h lat=%0d need=%h lat=%0d",
                         i, o, x, z, r, lat, e, LAT);
            else n_pass++;
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        n_checks  = 0;
        n_pass    = 0;
        Rst       = 1'b0;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        test_reset();
        test_basic_mul();
        test_directed();
        test_handshake();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
